// File: rtl/branch_target_predictor.sv
// Direct-mapped tagged BTB with 2-bit counters: Decode lookup, Execute resolve/train.
// Optional BTB_GSHARE_EN: counters indexed by PC index XOR global history.
module branch_target_predictor #(
    parameter int ENTRIES  = 256,
    parameter int TAG_BITS = 8,
    parameter int GHR_BITS = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] PCD,
    input  logic [6:0]  OPD,
    input  logic        FlushE,
    input  logic        BranchE,
    input  logic        JumpE,
    input  logic        PCSrcE,
    input  logic [31:0] PCE,
    input  logic [31:0] PCTargetE,
    output logic        PredTakenD,
    output logic [31:0] PredTargetD,
    output logic        MispredictE,
    output logic [31:0] RedirectPCE,
    output logic        FlushD_BP,
    output logic        FlushE_BP
);
    localparam int IDX = $clog2(ENTRIES);
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    logic                valid_r  [ENTRIES];
    logic [TAG_BITS-1:0] tag_r    [ENTRIES];
    logic [31:0]         target_r [ENTRIES];
    logic [1:0]          ctr_r    [ENTRIES];

    logic                pred_taken_e_r;
    logic [31:0]         pred_target_e_r;

    logic [IDX-1:0]      d_idx_s;
    logic [TAG_BITS-1:0] d_tag_s;
    logic [IDX-1:0]      d_ctr_idx_s;
    logic [IDX-1:0]      e_idx_s;
    logic [TAG_BITS-1:0] e_tag_s;
    logic [IDX-1:0]      e_ctr_idx_s;
    logic                d_hit_s;
    logic                e_hit_s;
    logic                resolve_s;
    logic [1:0]          ctr_cur_s;
    logic [1:0]          ctr_next_s;
    logic                unused_pc_bits_s;

    assign d_idx_s = PCD[IDX+1:2];
    assign d_tag_s = PCD[IDX+TAG_BITS+1:IDX+2];
    assign e_idx_s = PCE[IDX+1:2];
    assign e_tag_s = PCE[IDX+TAG_BITS+1:IDX+2];
    assign unused_pc_bits_s = ^{PCD, PCE};

`ifdef BTB_GSHARE_EN
    logic [GHR_BITS-1:0] ghr_r;
    logic [IDX-1:0]      ctr_idx_e_r;

    assign d_ctr_idx_s = d_idx_s ^ IDX'(ghr_r);
    assign e_ctr_idx_s = ctr_idx_e_r;

    // Global history shifts only on conditional branches; counter index follows the branch to E
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_r       <= '0;
            ctr_idx_e_r <= '0;
        end else begin
            ctr_idx_e_r <= d_ctr_idx_s;
            if (BranchE) begin
                ghr_r <= (ghr_r << 1) | GHR_BITS'(PCSrcE);
            end
        end
    end
`else
    assign d_ctr_idx_s = d_idx_s;
    assign e_ctr_idx_s = e_idx_s;
`endif

    // Decode lookup: zero-latency prediction
    always_comb begin
        d_hit_s     = valid_r[d_idx_s] && (tag_r[d_idx_s] == d_tag_s);
        PredTakenD  = d_hit_s && ((OPD == OP_JAL) ||
                                  ((OPD == OP_BRANCH) && ctr_r[d_ctr_idx_s][1]));
        if (PredTakenD) begin
            PredTargetD = target_r[d_idx_s];
        end else begin
            PredTargetD = PCD + 32'd4;
        end
    end

    // Execute resolution: compare tracked prediction against the real outcome
    always_comb begin
        resolve_s = BranchE || JumpE;
        if (resolve_s) begin
            MispredictE = (pred_taken_e_r != PCSrcE) ||
                          (pred_taken_e_r && PCSrcE && (pred_target_e_r != PCTargetE));
        end else begin
            MispredictE = 1'b0;
        end
        if (PCSrcE) begin
            RedirectPCE = PCTargetE;
        end else begin
            RedirectPCE = PCE + 32'd4;
        end
        FlushD_BP = MispredictE;
        FlushE_BP = MispredictE;
    end

    // Saturating counter step for the entry being trained
    always_comb begin
        e_hit_s   = valid_r[e_idx_s] && (tag_r[e_idx_s] == e_tag_s);
        ctr_cur_s = ctr_r[e_ctr_idx_s];
        case ({PCSrcE, ctr_cur_s})
            3'b111:  ctr_next_s = 2'b11;
            3'b000:  ctr_next_s = 2'b00;
            3'b100, 3'b101, 3'b110: ctr_next_s = ctr_cur_s + 2'd1;
            3'b001, 3'b010, 3'b011: ctr_next_s = ctr_cur_s - 2'd1;
            default: ctr_next_s = ctr_cur_s;
        endcase
    end

    // D->E prediction tracking; a bubble carries no prediction
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_taken_e_r  <= 1'b0;
            pred_target_e_r <= 32'd0;
        end else if (FlushE) begin
            pred_taken_e_r  <= 1'b0;
            pred_target_e_r <= 32'd0;
        end else begin
            pred_taken_e_r  <= PredTakenD;
            pred_target_e_r <= PredTargetD;
        end
    end

    // Table training; lookups in the same cycle see the old contents
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_r[i]  <= 1'b0;
                tag_r[i]    <= '0;
                target_r[i] <= 32'd0;
                ctr_r[i]    <= 2'b01;
            end
        end else if (resolve_s) begin
            if (e_hit_s) begin
                ctr_r[e_ctr_idx_s] <= ctr_next_s;
                if (PCSrcE) begin
                    target_r[e_idx_s] <= PCTargetE;
                end
            end else if (PCSrcE) begin
                valid_r[e_idx_s]   <= 1'b1;
                tag_r[e_idx_s]     <= e_tag_s;
                target_r[e_idx_s]  <= PCTargetE;
                ctr_r[e_ctr_idx_s] <= 2'b10;
            end
        end
    end
endmodule

// File: doc/branch_target_predictor.md
# branch_target_predictor

Parametrised successor to the pipeline's 2-bit branch predictor: a direct-mapped, tagged branch target buffer with per-entry 2-bit saturating counters, looked up in Decode and trained in Execute. It supplies a predicted next PC to Fetch, tracks its own prediction into Execute, and detects and reports mispredictions with a corrected PC and D/E flush requests. An optional global-history (gshare) mode decouples counter indexing from target storage.

## Interface
Parameters:
- ENTRIES, 256, number of BTB entries; power of two, ≥ 2; IDX = log2(ENTRIES)
- TAG_BITS, 8, tag width taken from PC above the index; IDX + TAG_BITS + 2 ≤ 32
- GHR_BITS, 8, global history length (used only with BTB_GSHARE_EN); 1 ≤ GHR_BITS ≤ IDX

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- PCD  in  32  Decode-stage PC
- OPD  in  7  Decode-stage opcode
- FlushE  in  1  hazard-unit bubble into Execute
- BranchE  in  1  Execute holds a conditional branch
- JumpE  in  1  Execute holds JAL
- PCSrcE  in  1  actual resolved taken
- PCE  in  32  Execute-stage PC
- PCTargetE  in  32  resolved target
- PredTakenD  out  1  predicted taken for PCD
- PredTargetD  out  32  predicted next PC
- MispredictE  out  1  misprediction in Execute
- RedirectPCE  out  32  corrected next PC
- FlushD_BP  out  1  flush Decode
- FlushE_BP  out  1  flush Execute

## Operation
- Index = PC[IDX+1:2]; tag = PC[IDX+TAG_BITS+1:IDX+2]. Entry = {valid, tag, target[31:0], ctr[1:0]}.
- Hit = valid & tag match on PCD. Conditional branch = OPD 7'b1100011; jump = OPD 7'b1101111.
- PredTakenD = hit & (jump | (cond & ctr[1])). PredTargetD = PredTakenD ? target : PCD + 4 (32-bit wrap).
- E-stage registers: predTakenE, predTargetE, ctrIdxE. Loaded each edge from D values; FlushE loads predTakenE = 0, predTargetE = 0.
- Resolution (BranchE | JumpE): MispredictE = (predTakenE != PCSrcE) | (predTakenE & PCSrcE & (predTargetE != PCTargetE)); otherwise 0.
- RedirectPCE = PCSrcE ? PCTargetE : PCE + 4. FlushD_BP = FlushE_BP = MispredictE.
- Training at edge when BranchE | JumpE, using PCE:
  - Hit: ctr saturating +1 if PCSrcE, −1 if not (11 stays 11, 00 stays 00); target ← PCTargetE if PCSrcE.
  - Miss and PCSrcE: allocate/replace: valid = 1, tag, target = PCTargetE, ctr = 2'b10.
  - Miss and !PCSrcE: no change.
- Same-index read and write in one cycle: D lookup sees pre-edge contents; no bypass.
- Neither BranchE nor JumpE: table, history unchanged; Mispredict outputs 0.

## Timing
- Reset (async, rst_n low): all valid = 0, all ctr = 2'b01, E-stage registers 0, GHR 0. Outputs during reset: PredTakenD = 0, PredTargetD = PCD + 4, MispredictE = 0, flushes 0, RedirectPCE combinational from PCE/PCSrcE.
- Lookup: combinational, zero latency from PCD/OPD.
- D→E prediction tracking: 1 cycle.
- Mispredict/redirect: combinational in Execute, same cycle as resolution.
- Training visible to D lookup the cycle after the resolving edge.
- Reset deasserted mid-stream: first edge after release trains normally.

## Configuration
- BTB_GSHARE_EN defined: counters in separate ENTRIES-deep array indexed by PC index XOR zero-extended GHR[GHR_BITS-1:0]; ctrIdxE carries that index to E for training; GHR shifts left with PCSrcE at each edge where BranchE (conditional only; JAL excluded). Tag/target still PC-indexed.
- Undefined: counter stored per entry, indexed by PC index; no GHR flops.

## Test plan
- After reset, PCD = 0x40, OPD = 1100011 -> PredTakenD = 0, PredTargetD = 0x44.
- Branch at 0x40 resolves taken to 0x10 (predicted not) -> MispredictE = 1, RedirectPCE = 0x10, both flushes 1; next lookup of 0x40 -> PredTakenD = 1, PredTargetD = 0x10.
- Same branch then not taken twice -> ctr 10 → 01 → 00; second resolution MispredictE = 0, RedirectPCE = 0x44.
- Alias: PC 0x40 allocated, then PC 0x40 + 4·ENTRIES queried -> tag miss, PredTakenD = 0.
- Correct target but taken mismatch vs target change: predicted 0x10, resolves taken to 0x20 -> MispredictE = 1, entry target becomes 0x20; FlushE during D→E transfer -> predTakenE cleared.
- With BTB_GSHARE_EN: pattern T,N repeated at one PC for 20 iterations -> zero mispredictions in final 4; without macro mispredictions persist.
